// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive frame sequencer.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    DONE
  } rx_state_e;

  localparam int unsigned DATA_WIDTH_DEF = 8;
  localparam int unsigned PRESC_W_DEF    = 6;
  localparam int unsigned BIT_W          = 4;

  localparam int unsigned PRESC_8  = 8;
  localparam int unsigned PRESC_16 = 16;
  localparam int unsigned PRESC_32 = 32;

  function automatic logic is_legal_presc(input int unsigned p);
    return (p == PRESC_8) || (p == PRESC_16) || (p == PRESC_32);
  endfunction

  // Oversampling edge at which the sampler's majority vote is available.
  function automatic int unsigned samp_point(input int unsigned p);
    return (p / 2) + 2;
  endfunction

endpackage

// File: rtl/uart_rx_fsm_if.sv
// Control/status bundle between the RX frame sequencer and the RX datapath.
interface uart_rx_fsm_if
  import uart_rx_pkg::*;
#(
  parameter int unsigned PRESC_W = PRESC_W_DEF
) ();

  logic               RX_IN;
  logic               PAR_EN;
  logic [PRESC_W-1:0] Prescale;
  logic               strt_glitch;
  logic               par_err;
  logic               stp_err;

  logic               dat_samp_en;
  logic               deser_en;
  logic               strt_chk_en;
  logic               par_chk_en;
  logic               stp_chk_en;
  logic               data_valid;
  logic [PRESC_W-1:0] edge_cnt;
  logic [BIT_W-1:0]   bit_cnt;

  modport master (
    input  RX_IN, PAR_EN, Prescale, strt_glitch, par_err, stp_err,
    output dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en,
           data_valid, edge_cnt, bit_cnt
  );

  modport slave (
    output RX_IN, PAR_EN, Prescale, strt_glitch, par_err, stp_err,
    input  dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en,
           data_valid, edge_cnt, bit_cnt
  );

endinterface

// File: rtl/uart_rx_edge_bit_cnt.sv
// Oversampling edge counter and frame bit counter; edge wraps at wrap_val.
module uart_rx_edge_bit_cnt
  import uart_rx_pkg::*;
#(
  parameter int unsigned PRESC_W = PRESC_W_DEF
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               en,
  input  logic               clr,
  input  logic [PRESC_W-1:0] wrap_val,
  output logic [PRESC_W-1:0] edge_cnt,
  output logic [BIT_W-1:0]   bit_cnt,
  output logic [PRESC_W-1:0] edge_nxt_c
);

  logic [BIT_W-1:0] bit_nxt;

  // Clear dominates enable.
  always_comb begin
    edge_nxt_c = edge_cnt;
    bit_nxt    = bit_cnt;
    if (clr) begin
      edge_nxt_c = '0;
      bit_nxt    = '0;
    end else if (en) begin
      if (edge_cnt == wrap_val) begin
        edge_nxt_c = '0;
        bit_nxt    = bit_cnt + BIT_W'(1);
      end else begin
        edge_nxt_c = edge_cnt + PRESC_W'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else begin
      edge_cnt <= edge_nxt_c;
      bit_cnt  <= bit_nxt;
    end
  end

endmodule

// File: rtl/uart_rx_fsm.sv
// UART RX frame sequencer: start detection, bit/edge tracking, one-cycle
// check/shift strobes and byte qualification. All outputs are registered.
module uart_rx_fsm
  import uart_rx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned PRESC_W    = PRESC_W_DEF
) (
  input logic           CLK,
  input logic           RST,
  uart_rx_fsm_if.master bus
);

  rx_state_e          state_q, state_nxt;
  logic [PRESC_W-1:0] p_q, p_nxt, p_last, presc_in, samp_nxt;
  logic [PRESC_W-1:0] edge_q, edge_nxt_c;
  logic [BIT_W-1:0]   bit_q;
  logic               cnt_en, cnt_clr, at_wrap, hit;
  logic               samp_q, deser_q, strt_q, par_q, stp_q, valid_q;
  logic               samp_d, deser_d, strt_d, par_d, stp_d, valid_d;

  // Illegal ratios fall back to 16 so the counters always have a sane period.
  assign presc_in = is_legal_presc(32'(bus.Prescale)) ? bus.Prescale : PRESC_W'(PRESC_16);
  assign p_last   = p_q - PRESC_W'(1);
  assign at_wrap  = (edge_q == p_last);

  // Next state, latched prescale and byte qualification.
  always_comb begin
    state_nxt = state_q;
    p_nxt     = p_q;
    valid_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!bus.RX_IN) begin
          state_nxt = START;
          p_nxt     = presc_in;
        end
      end
      START: begin
        if (at_wrap) state_nxt = bus.strt_glitch ? IDLE : DATA;
      end
      DATA: begin
        if (at_wrap && (bit_q == BIT_W'(DATA_WIDTH))) state_nxt = bus.PAR_EN ? PARITY : STOP;
      end
      PARITY: begin
        if (at_wrap) state_nxt = STOP;
      end
      STOP: begin
        if (at_wrap) begin
          state_nxt = DONE;
          valid_d   = !bus.stp_err && !(bus.PAR_EN && bus.par_err);
        end
      end
      DONE: begin
        if (bus.RX_IN) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = START;
          p_nxt     = presc_in;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign cnt_en  = state_q inside {START, DATA, PARITY, STOP};
  assign cnt_clr = !cnt_en || (state_nxt inside {IDLE, DONE});

  uart_rx_edge_bit_cnt #(
    .PRESC_W (PRESC_W)
  ) u_cnt (
    .CLK        (CLK),
    .RST        (RST),
    .en         (cnt_en),
    .clr        (cnt_clr),
    .wrap_val   (p_last),
    .edge_cnt   (edge_q),
    .bit_cnt    (bit_q),
    .edge_nxt_c (edge_nxt_c)
  );

  // Strobes for the next cycle, decoded from next state and next edge index.
  always_comb begin
    samp_nxt = PRESC_W'(samp_point(32'(p_nxt)));
    hit      = (edge_nxt_c == samp_nxt);
    samp_d   = (state_nxt != IDLE);
    strt_d   = hit && (state_nxt == START);
    deser_d  = hit && (state_nxt == DATA);
    par_d    = hit && (state_nxt == PARITY);
    stp_d    = hit && (state_nxt == STOP);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      p_q     <= PRESC_W'(PRESC_8);
      samp_q  <= 1'b0;
      deser_q <= 1'b0;
      strt_q  <= 1'b0;
      par_q   <= 1'b0;
      stp_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_nxt;
      p_q     <= p_nxt;
      samp_q  <= samp_d;
      deser_q <= deser_d;
      strt_q  <= strt_d;
      par_q   <= par_d;
      stp_q   <= stp_d;
      valid_q <= valid_d;
    end
  end

  assign bus.dat_samp_en = samp_q;
  assign bus.deser_en    = deser_q;
  assign bus.strt_chk_en = strt_q;
  assign bus.par_chk_en  = par_q;
  assign bus.stp_chk_en  = stp_q;
  assign bus.data_valid  = valid_q;
  assign bus.edge_cnt    = edge_q;
  assign bus.bit_cnt     = bit_q;

endmodule

// File: doc/uart_rx_fsm.md
# uart_rx_fsm

Frame-sequencing controller for the UART receiver. It detects the falling edge of a start bit and tracks oversampling edges and bit positions. It issues one-cycle enables to the sampler, deserializer and the start/parity/stop checkers, and qualifies the received byte with `data_valid`. It sits between the serial input pin logic and the RX checker/deserializer datapath, in the UART RX clock domain.

## Interface
- `DATA_WIDTH`, 8, number of data bits per frame
- `PRESC_W`, 6, width of prescale and edge counter
- `CLK` input 1 UART RX clock (oversampling clock)
- `RST` input 1 reset, asynchronous, active-low
- `RX_IN` input 1 synchronized serial line, idle high
- `PAR_EN` input 1 parity bit present in frame
- `Prescale` input PRESC_W oversampling ratio; legal values 8, 16, 32
- `strt_glitch` input 1 start checker result
- `par_err` input 1 parity checker result
- `stp_err` input 1 stop checker result
- `dat_samp_en` output 1 sampler enable, high in every non-IDLE state
- `deser_en` output 1 one-cycle shift strobe for deserializer
- `strt_chk_en` output 1 one-cycle start check strobe
- `par_chk_en` output 1 one-cycle parity check strobe
- `stp_chk_en` output 1 one-cycle stop check strobe
- `data_valid` output 1 one-cycle pulse, byte good
- `edge_cnt` output PRESC_W oversampling edge index, 0..P-1
- `bit_cnt` output 4 bit index within frame (0 = start)

## Operation
- P = `Prescale`, latched into an internal register on the IDLE->START transition. Later changes to `Prescale` are ignored until the next frame.
- Sample point S = P/2 + 2. The sampler's 3-sample majority is registered and valid at edge S.
- States:
  - IDLE -> START when `RX_IN`=0.
  - START: at edge S, `strt_chk_en`. At edge P-1, if `strt_glitch`=1 -> IDLE, else -> DATA.
  - DATA: at edge S, `deser_en`. At edge P-1 of bit DATA_WIDTH -> PARITY if `PAR_EN`, else -> STOP.
  - PARITY: at edge S, `par_chk_en`. At edge P-1 -> STOP.
  - STOP: at edge S, `stp_chk_en`. At edge P-1 -> DONE.
  - DONE: single cycle. `data_valid`=1 iff `par_err`=0 (or `PAR_EN`=0) and `stp_err`=0. Then -> START if `RX_IN`=0, else -> IDLE.
- Counter:
  - `edge_cnt` increments every cycle outside IDLE/DONE.
  - At P-1, `edge_cnt` wraps to 0 and `bit_cnt` increments.
  - `edge_cnt` and `bit_cnt` clear in IDLE, in DONE, and on any return to IDLE.
- Strobes are mutually exclusive; at most one is high per cycle.
- A glitch abort produces no `deser_en` and no `data_valid`.

## Timing
- Reset: state IDLE; all outputs 0; `edge_cnt`=0, `bit_cnt`=0; latched P=8.
- All outputs are registered-state decoded (Moore). No combinational path from `RX_IN` to any output.
- First START cycle has `edge_cnt`=0, i.e. one CLK after `RX_IN` is seen low in IDLE.
- Frame length in CLK cycles: P × (2 + DATA_WIDTH + PAR_EN), plus 1 DONE cycle.
- `data_valid` is high exactly in the DONE cycle. The deserializer output must be stable from the last `deser_en` through DONE.
- Back-to-back frames: `RX_IN`=0 in DONE -> START next cycle with `edge_cnt`=0, with no IDLE cycle.
- Reset mid-frame returns to IDLE immediately and clears everything; no `data_valid`.
- `RX_IN` activity during a frame is ignored by the FSM; only the sampler uses it.

## Structure
- Package `uart_rx_pkg`:
  - state enum (IDLE, START, DATA, PARITY, STOP, DONE)
  - legal prescale constants
  - `DATA_WIDTH` default
- Sub-module `uart_rx_edge_bit_cnt`: edge/bit counter with enable, wrap at P-1 and synchronous clear. The FSM instantiates it and drives enable and clear.

## Test plan
- P=8, `PAR_EN`=0, byte 0xA5, clean stop -> 8 `deser_en` pulses at edge 6, and `data_valid` at cycle 80 after START entry.
- P=16, `PAR_EN`=1, byte 0x3C, `par_err` forced 1 -> `par_chk_en` at bit 9 edge 10, and no `data_valid`.
- P=16, `RX_IN` low for 3 cycles only (`strt_glitch`=1) -> return to IDLE at edge 15 of START, with zero `deser_en`.
- P=32, two back-to-back frames 0x55, 0xFF -> second START entered directly from DONE, and two `data_valid` pulses 321 cycles apart.
- `stp_err`=1 on the stop bit -> `stp_chk_en` fires once and `data_valid` stays 0. `Prescale` changed mid-frame to 8 -> current frame keeps 16.
- `RST` asserted at DATA bit 4 -> all outputs 0 asynchronously, and the next falling edge frames correctly.
